// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit accumulator CPU control path.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  // Sequencer states, 4-bit encoding.
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH0 = 4'd1,
    FETCH1 = 4'd2,
    DECODE = 4'd3,
    RD_LO  = 4'd4,
    RD_HI  = 4'd5,
    WR_LO  = 4'd6,
    WR_HI  = 4'd7,
    EXEC   = 4'd8,
    HALT   = 4'd9,
    TRAP   = 4'd10
  } state_t;

  // Instructions whose first byte has bit 7 set carry a second byte.
  function automatic logic [1:0] inst_len(input logic [BYTE_W-1:0] first_byte);
    return first_byte[BYTE_W-1] ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/bus_byte_port.sv
// Byte-wide bus master port: holds a registered request until it is acked.
// A new request issued on the ack edge keeps mem_req high (back-to-back cycles).
module bus_byte_port
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic              issue_we,
  input  logic [WORD_W-1:0] issue_addr,
  input  logic [BYTE_W-1:0] issue_wdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              done
);

  // An ack only counts while a request is outstanding.
  assign done = mem_req & mem_ack;

  // Request holder: load on issue, drop on completion, otherwise hold stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue) begin
      mem_req   <= 1'b1;
      mem_we    <= issue_we;
      mem_addr  <= issue_addr;
      mem_wdata <= issue_wdata;
    end else if (done) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Control FSM for the accumulator CPU: fetch, decode window, operand
// read/store as two byte cycles, one-cycle execute and halt/trap stops.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [WORD_W-1:0] inst,
  output logic              dec_en,
  input  logic [1:0]        dec_bytes,
  input  logic              dec_halt,
  input  logic              dec_trap,
  input  logic              dec_mem_rd,
  input  logic              dec_store,
  input  logic [WORD_W-1:0] eff_addr,
  input  logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] operand,
  output logic              exec,
  input  logic              pc_load,
  input  logic [WORD_W-1:0] pc_target,
  output logic [WORD_W-1:0] pc,
  output logic              halted,
  output logic              trapped
);

  state_t            state, state_next;
  logic [WORD_W-1:0] pc_next, inst_next, operand_next;
  logic [WORD_W-1:0] addr_reg, addr_next;
  logic [WORD_W-1:0] pc_inc, addr_inc, exec_pc;
  logic              issue, issue_we, done;
  logic [WORD_W-1:0] issue_addr;
  logic [BYTE_W-1:0] issue_wdata;

  assign pc_inc   = pc + 16'd1;
  assign addr_inc = addr_reg + 16'd1;
  assign exec_pc  = pc_load ? pc_target : pc;

  assign dec_en  = (state == DECODE) || (state == RD_LO) || (state == RD_HI) ||
                   (state == WR_LO)  || (state == WR_HI) || (state == EXEC);
  assign exec    = (state == EXEC);
  assign halted  = (state == HALT);
  assign trapped = (state == TRAP);

  bus_byte_port u_port (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue       (issue),
    .issue_we    (issue_we),
    .issue_addr  (issue_addr),
    .issue_wdata (issue_wdata),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .done        (done)
  );

  // State register plus PC, instruction, operand and operand-address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      inst     <= '0;
      operand  <= '0;
      addr_reg <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      inst     <= inst_next;
      operand  <= operand_next;
      addr_reg <= addr_next;
    end
  end

  // Next-state logic; bus requests are issued on the edge that enters a bus state.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    inst_next    = inst;
    operand_next = operand;
    addr_next    = addr_reg;
    issue        = 1'b0;
    issue_we     = 1'b0;
    issue_addr   = '0;
    issue_wdata  = '0;
    case (state)
      IDLE: begin
        if (run) begin
          state_next = FETCH0;
          issue      = 1'b1;
          issue_addr = pc;
        end
      end
      FETCH0: begin
        if (done) begin
          inst_next = {mem_rdata, 8'h00};
          pc_next   = pc_inc;
          if (inst_len(mem_rdata) == 2'd2) begin
            state_next = FETCH1;
            issue      = 1'b1;
            issue_addr = pc_inc;
          end else begin
            state_next = DECODE;
          end
        end
      end
      FETCH1: begin
        if (done) begin
          inst_next[7:0] = mem_rdata;
          pc_next        = pc_inc;
          state_next     = DECODE;
        end
      end
      DECODE: begin
        addr_next = eff_addr;
        if (dec_halt) begin
          state_next = HALT;
        end else if (dec_trap) begin
          state_next = TRAP;
        end else if (dec_mem_rd) begin
          state_next = RD_LO;
          issue      = 1'b1;
          issue_addr = eff_addr;
        end else if (dec_store) begin
          state_next  = WR_LO;
          issue       = 1'b1;
          issue_we    = 1'b1;
          issue_addr  = eff_addr;
          issue_wdata = store_data[7:0];
        end else begin
          state_next = EXEC;
        end
      end
      RD_LO: begin
        if (done) begin
          operand_next[7:0] = mem_rdata;
          state_next        = RD_HI;
          issue             = 1'b1;
          issue_addr        = addr_inc;
        end
      end
      RD_HI: begin
        if (done) begin
          operand_next[15:8] = mem_rdata;
          state_next         = EXEC;
        end
      end
      WR_LO: begin
        if (done) begin
          state_next  = WR_HI;
          issue       = 1'b1;
          issue_we    = 1'b1;
          issue_addr  = addr_inc;
          issue_wdata = store_data[15:8];
        end
      end
      WR_HI: begin
        if (done) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        pc_next = exec_pc;
        if (run) begin
          state_next = FETCH0;
          issue      = 1'b1;
          issue_addr = exec_pc;
        end else begin
          state_next = IDLE;
        end
      end
      HALT:    state_next = HALT;
      TRAP:    state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  // The decoder's reported length must match the number of bytes fetched.
  always_ff @(posedge clk) begin
    if (rst_n && (state == DECODE)) begin
      assert (dec_bytes == inst_len(inst[15:8]))
        else $error("dec_bytes disagrees with fetched instruction length");
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed vector table, hand-written corner
// sequences and randomized programs checked against an instruction-level model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [15:0] inst, operand, pc, eff_addr, store_data, pc_target;
  logic        dec_en, dec_halt, dec_trap, dec_mem_rd, dec_store, exec, pc_load;
  logic        halted, trapped;
  logic [1:0]  dec_bytes;

  int checks = 0;
  int failures = 0;

  // Bus responder and memory
  logic [7:0] mem [0:65535];
  logic [7:0] mm  [0:65535];
  int   wait_n = 0;
  int   cnt = 0;
  logic force_ack = 1'b0;

  // Decoder stand-in with operand overrides for directed tests
  logic        ovr_en = 1'b0;
  logic [15:0] ea_ovr = 16'h0, sd_ovr = 16'h0;
  logic [7:0]  op;

  always #5 clk = ~clk;

  assign mem_ack    = (mem_req && (cnt == wait_n)) || force_ack;
  assign mem_rdata  = mem[mem_addr];
  assign op         = inst[15:8];
  assign dec_bytes  = op[7] ? 2'd2 : 2'd1;
  assign dec_halt   = (op == 8'h01);
  assign dec_trap   = (op == 8'h02);
  assign dec_mem_rd = op[7] && (op[6:4] == 3'd1);
  assign dec_store  = op[7] && (op[6:4] == 3'd2);
  assign pc_load    = op[7] && (op[6:4] == 3'd4);
  assign pc_target  = {8'h00, inst[7:0]};
  assign eff_addr   = ovr_en ? ea_ovr : {inst[7:0] ^ 8'h5A, inst[7:0]};
  assign store_data = ovr_en ? sd_ovr : {inst[7:0], ~inst[7:0]};

  always @(posedge clk) begin
    if (!mem_req || mem_ack) cnt <= 0;
    else cnt <= cnt + 1;
    if (mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
  end

  cpu_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .inst(inst), .dec_en(dec_en), .dec_bytes(dec_bytes), .dec_halt(dec_halt),
    .dec_trap(dec_trap), .dec_mem_rd(dec_mem_rd), .dec_store(dec_store),
    .eff_addr(eff_addr), .store_data(store_data), .operand(operand), .exec(exec),
    .pc_load(pc_load), .pc_target(pc_target), .pc(pc), .halted(halted), .trapped(trapped)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; force_ack = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_req", {mem_req, mem_we, dec_en, exec, halted, trapped}, 6'b0);
    chk("rst_inst_operand", {inst, operand}, 32'h0);
    chk("rst_addr_wdata", {mem_addr, mem_wdata}, 24'h0);
    rst_n = 1'b1;
  endtask

  // Directed vector table
  typedef struct {
    logic [7:0]  b0, b1;
    int          waitn;
    logic [15:0] ea, sd;
    logic [15:0] exp_inst;
    int          exp_lat, exp_ntx;
    logic [15:0] exp_next;
    logic        exp_halt, exp_trap, chk_store;
  } vec_t;

  vec_t vt [9];

  // Instruction-level reference model for random programs
  typedef struct packed { logic we; logic [15:0] addr; logic [7:0] wdata; } tx_t;
  typedef struct packed { logic [15:0] inst, operand, pc_after; logic chk_op; } ex_t;
  tx_t txq [$];
  ex_t exq [$];
  int  end_kind, nexec;

  task automatic model_run(input int n);
    logic [15:0] p, ea, ea1, sd;
    logic [7:0]  b0, b1;
    p = 16'h0000; end_kind = 0; nexec = 0;
    for (int k = 0; k < n; k++) begin
      b0 = mm[p]; txq.push_back({1'b0, p, 8'h00}); p = p + 16'd1; b1 = 8'h00;
      if (b0[7]) begin b1 = mm[p]; txq.push_back({1'b0, p, 8'h00}); p = p + 16'd1; end
      if (b0 == 8'h01) begin end_kind = 1; break; end
      if (b0 == 8'h02) begin end_kind = 2; break; end
      ea = {b1 ^ 8'h5A, b1}; ea1 = ea + 16'd1; sd = {b1, ~b1};
      if (b0[7] && b0[6:4] == 3'd1) begin
        txq.push_back({1'b0, ea, 8'h00}); txq.push_back({1'b0, ea1, 8'h00});
        exq.push_back({b0, b1, mm[ea1], mm[ea], 16'h0, 1'b1});
      end else begin
        if (b0[7] && b0[6:4] == 3'd2) begin
          txq.push_back({1'b1, ea, sd[7:0]}); mm[ea] = sd[7:0];
          txq.push_back({1'b1, ea1, sd[15:8]}); mm[ea1] = sd[15:8];
        end
        exq.push_back({b0, b1, 16'h0, 16'h0, 1'b0});
      end
      if (b0[7] && b0[6:4] == 3'd4) p = {8'h00, b1};
      exq[exq.size()-1].pc_after = p;
      nexec++;
    end
  endtask

  initial begin
    vec_t v;
    int   lat, ntx, execs, guard;
    logic fin, pend_pc, prev_wait;
    logic [15:0] exp_pc, prev_addr;
    logic [15:0] rd_addrs [$];
    tx_t  t;
    ex_t  e;

    vt[0] = '{8'h00, 8'h00, 0, 16'h0100, 16'h0000, 16'h0000, 3,  1, 16'h0001, 0, 0, 0};
    vt[1] = '{8'h88, 8'h05, 0, 16'h0100, 16'h0000, 16'h8805, 4,  2, 16'h0002, 0, 0, 0};
    vt[2] = '{8'hA0, 8'h00, 0, 16'h0100, 16'hBEEF, 16'hA000, 6,  4, 16'h0002, 0, 0, 1};
    vt[3] = '{8'hC0, 8'h40, 0, 16'h0100, 16'h0000, 16'hC040, 4,  2, 16'h0040, 0, 0, 0};
    vt[4] = '{8'h01, 8'h00, 0, 16'h0100, 16'h0000, 16'h0100, 3,  1, 16'h0001, 1, 0, 0};
    vt[5] = '{8'h02, 8'h00, 0, 16'h0100, 16'h0000, 16'h0200, 3,  1, 16'h0001, 0, 1, 0};
    vt[6] = '{8'h88, 8'h05, 1, 16'h0100, 16'h0000, 16'h8805, 6,  2, 16'h0002, 0, 0, 0};
    vt[7] = '{8'hA0, 8'h00, 2, 16'h0100, 16'hBEEF, 16'hA000, 14, 4, 16'h0002, 0, 0, 1};
    vt[8] = '{8'h7F, 8'h00, 0, 16'h0100, 16'h0000, 16'h7F00, 3,  1, 16'h0001, 0, 0, 0};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    for (int i = 0; i < 9; i++) begin
      v = vt[i];
      do_reset();
      mem[0] = v.b0; mem[1] = v.b1; mem[v.ea] = 8'h00; mem[v.ea + 16'd1] = 8'h00;
      wait_n = v.waitn; ovr_en = 1'b1; ea_ovr = v.ea; sd_ovr = v.sd;
      run = 1'b1; lat = 0; ntx = 0; fin = 1'b0;
      while (!fin && lat < 200) begin
        @(posedge clk); lat++; @(negedge clk);
        if (mem_req && mem_ack) ntx++;
        if (exec || halted || trapped) fin = 1'b1;
      end
      $display("vec %0d b0=%02h b1=%02h wait=%0d lat=%0d ntx=%0d inst=%04h", i, v.b0, v.b1, v.waitn, lat, ntx, inst);
      chk($sformatf("vec%0d_latency", i), lat, v.exp_lat);
      chk($sformatf("vec%0d_inst", i), inst, v.exp_inst);
      chk($sformatf("vec%0d_ntx", i), ntx, v.exp_ntx);
      chk($sformatf("vec%0d_halt_trap", i), {halted, trapped}, {v.exp_halt, v.exp_trap});
      if (v.exp_halt || v.exp_trap) begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk($sformatf("vec%0d_stop_hold", i), {mem_req, halted, trapped, dec_en}, {1'b0, v.exp_halt, v.exp_trap, 1'b0});
        end
      end else begin
        chk($sformatf("vec%0d_dec_en", i), dec_en, 1'b1);
        @(negedge clk);
        chk($sformatf("vec%0d_exec_pulse", i), exec, 1'b0);
        chk($sformatf("vec%0d_next_fetch", i), {mem_req, mem_we, mem_addr}, {2'b10, v.exp_next});
        chk($sformatf("vec%0d_pc", i), pc, v.exp_next);
        if (v.chk_store) chk($sformatf("vec%0d_store_bytes", i), {mem[16'h0101], mem[16'h0100]}, 16'hBEEF);
      end
      run = 1'b0;
    end

    // Halt then reset for one cycle clears halted and reloads pc
    do_reset();
    mem[0] = 8'h01; wait_n = 0; run = 1'b1;
    repeat (4) @(negedge clk);
    chk("halt_seq_halted", {halted, mem_req}, 2'b10);
    do_reset();
    chk("halt_seq_cleared", {halted, pc}, 17'h0);

    // Load across the address wrap with slow bus: nop 0x12 at 0, load 0x90 at 1
    do_reset();
    mem[0] = 8'h12; mem[1] = 8'h90; mem[2] = 8'h00; mem[16'hFFFF] = 8'h34;
    wait_n = 3; ovr_en = 1'b1; ea_ovr = 16'hFFFF; sd_ovr = 16'h0;
    run = 1'b1; execs = 0; guard = 0; prev_wait = 1'b0; prev_addr = 16'h0;
    rd_addrs.delete();
    while (execs < 2 && guard < 200) begin
      @(posedge clk); guard++; @(negedge clk);
      if (prev_wait && mem_req) chk("load_req_stable", mem_addr, prev_addr);
      prev_wait = mem_req && !mem_ack; prev_addr = mem_addr;
      if (mem_req && mem_ack) rd_addrs.push_back(mem_addr);
      if (exec) begin
        execs++;
        if (execs == 2) run = 1'b0;
      end
    end
    chk("load_timeout", guard < 200, 1'b1);
    $display("load_wrap inst=%04h operand=%04h reads=%0d", inst, operand, rd_addrs.size());
    chk("load_inst", inst, 16'h9000);
    chk("load_operand", operand, 16'h1234);
    chk("load_ntx", rd_addrs.size(), 5);
    if (rd_addrs.size() == 5) begin
      chk("load_fetch_addrs", {rd_addrs[0], rd_addrs[1], rd_addrs[2]}, {16'h0000, 16'h0001, 16'h0002});
      chk("load_rd_addrs", {rd_addrs[3], rd_addrs[4]}, {16'hFFFF, 16'h0000});
    end
    @(negedge clk);
    chk("load_idle_after", {mem_req, pc}, {1'b0, 16'h0003});

    // Reset while a fetch waits; a late ack after release must be ignored
    do_reset();
    mem[0] = 8'h00; wait_n = 50; ovr_en = 1'b0; run = 1'b1;
    repeat (3) @(negedge clk);
    chk("inflight_req", {mem_req, mem_addr}, {1'b1, 16'h0000});
    rst_n = 1'b0; run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("inflight_req_dropped", mem_req, 1'b0);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("late_ack_ignored", {mem_req, dec_en, exec, pc, inst}, 35'h0);
    end
    $display("reset_inflight pc=%04h inst=%04h req=%0b", pc, inst, mem_req);

    // Randomized programs against the instruction-level model
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      for (int a = 0; a < 65536; a++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h01 || b == 8'h02) b = 8'h00;
        mem[a] = b; mm[a] = b;
      end
      txq.delete(); exq.delete();
      model_run(30);
      wait_n = ph; ovr_en = 1'b0;
      run = 1'b1; execs = 0; guard = 0; fin = 1'b0; pend_pc = 1'b0; exp_pc = 16'h0;
      while (!fin && guard < 5000) begin
        @(posedge clk); guard++; @(negedge clk);
        if (pend_pc) begin chk("rnd_pc", pc, exp_pc); pend_pc = 1'b0; end
        if (mem_req && mem_ack) begin
          if (txq.size() == 0) chk("rnd_extra_tx", 1'b1, 1'b0);
          else begin
            t = txq.pop_front();
            chk("rnd_tx_addr_we", {mem_we, mem_addr}, {t.we, t.addr});
            if (t.we) chk("rnd_tx_wdata", mem_wdata, t.wdata);
          end
        end
        if (exec) begin
          if (exq.size() == 0) chk("rnd_extra_exec", 1'b1, 1'b0);
          else begin
            e = exq.pop_front();
            $display("rnd ph=%0d exec=%0d inst=%04h operand=%04h", ph, execs, inst, operand);
            chk("rnd_inst", inst, e.inst);
            if (e.chk_op) chk("rnd_operand", operand, e.operand);
            exp_pc = e.pc_after; pend_pc = 1'b1;
          end
          execs++;
          if (execs == nexec && end_kind == 0) begin run = 1'b0; fin = 1'b1; end
        end
        if (halted || trapped) begin
          fin = 1'b1;
          chk("rnd_stop_kind", {halted, trapped}, {end_kind == 1, end_kind == 2});
        end
      end
      chk("rnd_timeout", guard < 5000, 1'b1);
      @(negedge clk);
      if (pend_pc) chk("rnd_pc_last", pc, exp_pc);
      chk("rnd_final_req", mem_req, 1'b0);
      chk("rnd_queues_empty", {txq.size() == 0, exq.size() == 0}, 2'b11);
      $display("rnd ph=%0d done execs=%0d end_kind=%0d", ph, execs, end_kind);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Top-level control FSM for the 16-bit accumulator CPU. It owns the PC and the instruction register, and fetches 1- or 2-byte instructions over a shared byte-wide memory bus using a req/ack handshake. It enables the combinational instruction decoder, performs the 16-bit operand read or store as two byte cycles, and issues a one-cycle execute strobe to the datapath. It also applies branch/call PC updates and stops on halt or trap.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
run  in  1  permit instruction issue; sampled only at instruction boundaries
mem_req  out  1  bus cycle request; held until ack
mem_we  out  1  1 = write cycle
mem_addr  out  16  byte address
mem_wdata  out  8  write byte
mem_rdata  in  8  read byte; valid in ack cycle
mem_ack  in  1  bus cycle complete this cycle
inst  out  16  instruction register, to decoder
dec_en  out  1  decoder enable
dec_bytes  in  2  decoder length: 1 or 2
dec_halt  in  1  decoded halt
dec_trap  in  1  decoded trap
dec_mem_rd  in  1  source_ram | source_indirect, excluding stores
dec_store  in  1  decoded store
eff_addr  in  16  operand effective address; valid while dec_en=1
store_data  in  16  accumulator value for store
operand  out  16  word read from memory, little-endian
exec  out  1  one-cycle execute strobe
pc_load  in  1  branch/call taken; sampled with exec
pc_target  in  16  new PC; sampled with exec
pc  out  16  program counter
halted  out  1  halt reached
trapped  out  1  trap reached

Behaviour:
- Reset, synchronous when rst_n=0 at a clk edge: state=IDLE, pc=RESET_PC, inst=0, operand=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dec_en=0, exec=0, halted=0, trapped=0. Reset overrides any bus cycle in flight; the sequencer ignores any later ack.
- States: IDLE, FETCH0, FETCH1, DECODE, RD_LO, RD_HI, WR_LO, WR_HI, EXEC, HALT, TRAP.
- Bus rules:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and stable from request until the ack cycle.
  - On an ack edge the FSM advances.
  - If the next state also uses the bus, mem_req stays 1 and mem_addr changes on the same edge. Otherwise mem_req drops.
  - A mem_ack seen while mem_req=0 is ignored.
- IDLE: when run=1, go to FETCH0 with mem_addr=pc.
- FETCH0: on ack, inst[15:8]=mem_rdata, inst[7:0]=0, pc=pc+1 (wraps FFFF to 0000). If mem_rdata[7]=1, go to FETCH1 at the new pc; otherwise go to DECODE.
- FETCH1: on ack, inst[7:0]=mem_rdata, pc=pc+1, go to DECODE.
- DECODE: lasts exactly 1 cycle with dec_en=1. Capture eff_addr into an internal address register. Next state by priority: dec_halt to HALT, dec_trap to TRAP, dec_mem_rd to RD_LO, dec_store to WR_LO, otherwise EXEC.
- dec_bytes must agree with the fetched length; a mismatch (assertion only) is a design error.
- RD_LO: read at addr, operand[7:0]=rdata. RD_HI: read at addr+1 (16-bit wrap), operand[15:8]=rdata. Then go to EXEC.
- WR_LO: write store_data[7:0] to addr. WR_HI: write store_data[15:8] to addr+1 (wrap). Then go to EXEC.
- EXEC: lasts 1 cycle with exec=1 and dec_en=1. If pc_load=1, pc=pc_target. Then go to FETCH0 if run=1, else IDLE.
- dec_en=1 in DECODE, RD_*, WR_* and EXEC; 0 elsewhere. inst is held constant for the whole window.
- HALT: halted=1. TRAP: trapped=1. Both are terminal until reset; mem_req=0 in both.
- Minimum latency, zero-wait bus (ack in the first request cycle):
  - 1-byte plain instruction: 3 cycles (F0, D, E).
  - 2-byte plain instruction: 4 cycles.
  - 2-byte with read or store: 6 cycles.
- Deasserting run mid-instruction has no effect until the next EXEC completes.

Decomposition:
- Shared package cpu_pkg: state enum (4-bit encoding), WORD_W=16, BYTE_W=8, RESET_PC default.
- One natural sub-module, bus_byte_port: registered req/we/addr/wdata holder plus ack capture, reused by the fetch, read and write states.

Test Plan:
- Reset, then run=1 with memory [0]=0x00 (nop), zero-wait: mem_addr 0, DECODE with inst=0x0000, exec pulse 3 cycles after the run edge, pc=1, next fetch at addr 1.
- Memory [0]=0x88, [1]=0x05 (add imm): two fetch cycles, inst=0x8805, no RD/WR cycle, exec asserted, pc=2.
- Load-from-RAM opcode with eff_addr=0xFFFF, memory [FFFF]=0x34, [0000]=0x12, ack delayed 3 cycles per access: reads at FFFF then 0000, operand=0x1234, req held stable during the waits.
- Store with eff_addr=0x0100, store_data=0xBEEF: writes 0xEF at 0x0100 then 0xBE at 0x0101, mem_we=1, then exec.
- Branch exec with pc_load=1, pc_target=0x0040: next fetch address 0x0040. Halt opcode 0x01: halted=1, mem_req stays 0. rst_n=0 for 1 cycle: pc=RESET_PC, halted=0.
- Reset asserted while a fetch is waiting for ack, with ack arriving 1 cycle after release: the late ack is ignored, IDLE is held with run=0, and no pc change occurs.
